// File: rtl/mul_unit.sv
// ============================================================================
// Module   : mul_unit
// Brief    : Iterative shift-add multiplier for register-file write-back.
//            The optional signed-operand path is enabled with MUL_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_hi,
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    output logic                  busy,
    output logic                  done,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [CNT_WIDTH-1:0] c_LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef MUL_SIGNED_EN
        , S_FIX = 2'd3
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH:0]   r_acc_hi;
    logic [DATA_WIDTH-1:0] r_acc_lo;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_op_hi;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_run_hi;
    logic [DATA_WIDTH-1:0] w_run_lo;
    logic [DATA_WIDTH-1:0] w_mcand_in;
    logic [DATA_WIDTH-1:0] w_mplier_in;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == c_LAST_ITER);

    // One shift-add step: conditional add keeps the carry, then the whole
    // {acc_hi, acc_lo} pair shifts right with zero fill.
    assign w_sum    = r_acc_lo[0] ? (r_acc_hi + {1'b0, r_mcand}) : r_acc_hi;
    assign w_run_hi = {1'b0, w_sum[DATA_WIDTH:1]};
    assign w_run_lo = {w_sum[0], r_acc_lo[DATA_WIDTH-1:1]};

`ifdef MUL_SIGNED_EN
    logic                    r_sign;
    logic                    w_sign_in;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_fix;

    // Signed requests run the unsigned core on magnitudes; FIX restores sign.
    assign w_mcand_in  = (op_signed && rs1_val[DATA_WIDTH-1]) ? (~rs1_val + 1'b1) : rs1_val;
    assign w_mplier_in = (op_signed && rs2_val[DATA_WIDTH-1]) ? (~rs2_val + 1'b1) : rs2_val;
    assign w_sign_in   = op_signed & (rs1_val[DATA_WIDTH-1] ^ rs2_val[DATA_WIDTH-1]);
    assign w_prod      = {r_acc_hi[DATA_WIDTH-1:0], r_acc_lo};
    assign w_fix       = r_sign ? (~w_prod + 1'b1) : w_prod;
`else
    logic w_unused_op_signed;

    // Unsigned-only build: op_signed has no effect.
    assign w_unused_op_signed = op_signed;
    assign w_mcand_in         = rs1_val;
    assign w_mplier_in        = rs2_val;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        we          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
`ifdef MUL_SIGNED_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done        = 1'b1;
                we          = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_op_hi  <= 1'b0;
            r_result <= '0;
`ifdef MUL_SIGNED_EN
            r_sign   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_mcand  <= w_mcand_in;
                r_acc_hi <= '0;
                r_acc_lo <= w_mplier_in;
                r_cnt    <= '0;
                r_op_hi  <= op_hi;
`ifdef MUL_SIGNED_EN
                r_sign   <= w_sign_in;
`endif
            end else if (r_state == S_RUN) begin
                r_acc_hi <= w_run_hi;
                r_acc_lo <= w_run_lo;
                r_cnt    <= r_cnt + 1'b1;
`ifndef MUL_SIGNED_EN
                // Result captured on the same edge that enters DONE.
                if (w_last) begin
                    r_result <= r_op_hi ? w_run_hi[DATA_WIDTH-1:0] : w_run_lo;
                end
`endif
            end
`ifdef MUL_SIGNED_EN
            else if (r_state == S_FIX) begin
                r_acc_hi <= {1'b0, w_fix[2*DATA_WIDTH-1:DATA_WIDTH]};
                r_acc_lo <= w_fix[DATA_WIDTH-1:0];
                r_result <= r_op_hi ? w_fix[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : w_fix[DATA_WIDTH-1:0];
            end
`endif
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire
